// File: rtl/stream_triplet_tx_pkg.sv
// Shared types and constants for the triplet packer.
package stream_triplet_pkg;

    localparam int TX_COUNT_W = 16;

    typedef enum logic [1:0] {
        COL_A = 2'd0,
        COL_B = 2'd1,
        COL_C = 2'd2,
        FLUSH = 2'd3
    } triplet_state_t;

endpackage

// File: rtl/stream_triplet_tx_if.sv
// Word-in / triplet-out handshake bundle. m_parity exists only with STREAM_TRIPLET_TX_PARITY_EN.
interface stream_triplet_tx_if
    import stream_triplet_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic                  s_valid;
    logic                  s_ready;
    logic [WIDTH-1:0]      s_data;
    logic                  s_last;
    logic                  m_valid;
    logic                  m_ready;
    logic [WIDTH-1:0]      lane_a;
    logic [WIDTH-1:0]      lane_b;
    logic [WIDTH-1:0]      lane_c;
    logic                  m_partial;
    logic                  m_last;
    logic [TX_COUNT_W-1:0] tx_count;
`ifdef STREAM_TRIPLET_TX_PARITY_EN
    logic                  m_parity;
`endif

    modport master (
`ifdef STREAM_TRIPLET_TX_PARITY_EN
        input  m_parity,
`endif
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, lane_a, lane_b, lane_c, m_partial, m_last, tx_count
    );

    modport slave (
`ifdef STREAM_TRIPLET_TX_PARITY_EN
        output m_parity,
`endif
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, lane_a, lane_b, lane_c, m_partial, m_last, tx_count
    );
endinterface

// File: rtl/stream_triplet_tx_out_reg.sv
// Output register O: triplet load, handshake tracking, handshake counter and optional parity
// (STREAM_TRIPLET_TX_PARITY_EN).
module triplet_out_reg
    import stream_triplet_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      lane_a_i,
    input  logic [WIDTH-1:0]      lane_b_i,
    input  logic [WIDTH-1:0]      lane_c_i,
    input  logic                  partial_i,
    input  logic                  last_i,
    input  logic                  m_ready_i,
    output logic                  m_valid_o,
    output logic [WIDTH-1:0]      lane_a_o,
    output logic [WIDTH-1:0]      lane_b_o,
    output logic [WIDTH-1:0]      lane_c_o,
    output logic                  m_partial_o,
    output logic                  m_last_o,
`ifdef STREAM_TRIPLET_TX_PARITY_EN
    output logic                  m_parity_o,
`endif
    output logic [TX_COUNT_W-1:0] tx_count_o
);
    logic                  m_valid_q, m_valid_d;
    logic [WIDTH-1:0]      lane_a_q, lane_b_q, lane_c_q;
    logic                  m_partial_q, m_last_q;
    logic [TX_COUNT_W-1:0] tx_count_q, tx_count_d;
    logic                  handshake;

    assign handshake = m_valid_q && m_ready_i;

    // A reload in the handshake cycle keeps m_valid high with the new triplet.
    always_comb begin
        m_valid_d = m_valid_q;
        if (load_i) begin
            m_valid_d = 1'b1;
        end else if (handshake) begin
            m_valid_d = 1'b0;
        end
        tx_count_d = handshake ? tx_count_q + 1'b1 : tx_count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_q   <= 1'b0;
            lane_a_q    <= '0;
            lane_b_q    <= '0;
            lane_c_q    <= '0;
            m_partial_q <= 1'b0;
            m_last_q    <= 1'b0;
            tx_count_q  <= '0;
        end else begin
            m_valid_q  <= m_valid_d;
            tx_count_q <= tx_count_d;
            if (load_i) begin
                lane_a_q    <= lane_a_i;
                lane_b_q    <= lane_b_i;
                lane_c_q    <= lane_c_i;
                m_partial_q <= partial_i;
                m_last_q    <= last_i;
            end
        end
    end

`ifdef STREAM_TRIPLET_TX_PARITY_EN
    logic m_parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_parity_q <= 1'b0;
        end else if (load_i) begin
            m_parity_q <= ^(lane_a_i ^ lane_b_i ^ lane_c_i);
        end
    end

    assign m_parity_o = m_parity_q;
`endif

    assign m_valid_o   = m_valid_q;
    assign lane_a_o    = lane_a_q;
    assign lane_b_o    = lane_b_q;
    assign lane_c_o    = lane_c_q;
    assign m_partial_o = m_partial_q;
    assign m_last_o    = m_last_q;
    assign tx_count_o  = tx_count_q;

endmodule

// File: rtl/stream_triplet_tx.sv
// Round-robin packer of a word stream into A/B/C lane triplets; s_last closes a zero-filled
// partial triplet. Optional m_parity with STREAM_TRIPLET_TX_PARITY_EN.
//
// state | meaning
// COL_A | waiting for word 0 (lane A)
// COL_B | waiting for word 1 (lane B)
// COL_C | waiting for word 2, accepted only when O is free
// FLUSH | early s_last taken, loading a partial triplet into O
module stream_triplet_tx
    import stream_triplet_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    stream_triplet_tx_if.slave  bus
);
    triplet_state_t   state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             flush_b_q;
    logic             o_free, accept;
    logic             load;
    logic [WIDTH-1:0] ld_a, ld_b, ld_c;
    logic             ld_partial, ld_last;
    logic             s_ready;

    assign o_free = !bus.m_valid || bus.m_ready;
    assign accept = bus.s_valid && s_ready;
    assign bus.s_ready = s_ready;

    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            COL_A, COL_B: s_ready = 1'b1;
            COL_C:        s_ready = o_free;
            default:      s_ready = 1'b0;
        endcase
    end

    always_comb begin
        load       = 1'b0;
        ld_a       = a_q;
        ld_b       = b_q;
        ld_c       = bus.s_data;
        ld_partial = 1'b0;
        ld_last    = bus.s_last;
        case (state_q)
            COL_C: load = accept;
            FLUSH: begin
                load       = o_free;
                ld_b       = flush_b_q ? b_q : '0;
                ld_c       = '0;
                ld_partial = 1'b1;
                ld_last    = 1'b1;
            end
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= COL_A;
            a_q       <= '0;
            b_q       <= '0;
            flush_b_q <= 1'b0;
        end else begin
            case (state_q)
                COL_A: if (accept) begin
                    a_q <= bus.s_data;
                    if (bus.s_last) begin
                        flush_b_q <= 1'b0;
                        state_q   <= FLUSH;
                    end else begin
                        state_q <= COL_B;
                    end
                end
                COL_B: if (accept) begin
                    b_q <= bus.s_data;
                    if (bus.s_last) begin
                        flush_b_q <= 1'b1;
                        state_q   <= FLUSH;
                    end else begin
                        state_q <= COL_C;
                    end
                end
                COL_C: if (accept) state_q <= COL_A;
                FLUSH: if (o_free) state_q <= COL_A;
                default: state_q <= COL_A;
            endcase
        end
    end

    triplet_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .lane_a_i    (ld_a),
        .lane_b_i    (ld_b),
        .lane_c_i    (ld_c),
        .partial_i   (ld_partial),
        .last_i      (ld_last),
        .m_ready_i   (bus.m_ready),
        .m_valid_o   (bus.m_valid),
        .lane_a_o    (bus.lane_a),
        .lane_b_o    (bus.lane_b),
        .lane_c_o    (bus.lane_c),
        .m_partial_o (bus.m_partial),
        .m_last_o    (bus.m_last),
`ifdef STREAM_TRIPLET_TX_PARITY_EN
        .m_parity_o  (bus.m_parity),
`endif
        .tx_count_o  (bus.tx_count)
    );

endmodule

// File: tb/tb_stream_triplet_tx.sv
// Directed bench for stream_triplet_tx; parity checks compile in with STREAM_TRIPLET_TX_PARITY_EN.
module tb_stream_triplet_tx;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    stream_triplet_tx_if #(.WIDTH(16)) bus ();

    stream_triplet_tx #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Offer one word at a negedge; returns at the negedge after its accept edge.
    task automatic push(input logic [15:0] d, input logic l);
        int t;
        t = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        #1;
        while (!bus.s_ready && t < 50) begin
            step();
            #1;
            t++;
        end
        if (t >= 50) begin
            n_assert++;
            n_fail++;
            $error("FAIL push_timeout: observed s_ready=0 expected s_ready=1 for word %0h", d);
        end
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_data  = 16'hDEAD;
        bus.s_last  = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic p, input logic l);
        chk({tag, "_valid"},   {31'd0, bus.m_valid},   32'd1);
        chk({tag, "_lane_a"},  {16'd0, bus.lane_a},    {16'd0, a});
        chk({tag, "_lane_b"},  {16'd0, bus.lane_b},    {16'd0, b});
        chk({tag, "_lane_c"},  {16'd0, bus.lane_c},    {16'd0, c});
        chk({tag, "_partial"}, {31'd0, bus.m_partial}, {31'd0, p});
        chk({tag, "_last"},    {31'd0, bus.m_last},    {31'd0, l});
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 16'h0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b1;

        // Reset state
        @(negedge clk);
        step();
        chk("rst_valid",   {31'd0, bus.m_valid},   32'd0);
        chk("rst_lane_a",  {16'd0, bus.lane_a},    32'd0);
        chk("rst_lane_c",  {16'd0, bus.lane_c},    32'd0);
        chk("rst_partial", {31'd0, bus.m_partial}, 32'd0);
        chk("rst_last",    {31'd0, bus.m_last},    32'd0);
        chk("rst_count",   {16'd0, bus.tx_count},  32'd0);
        chk("rst_s_ready", {31'd0, bus.s_ready},   32'd1);
`ifdef STREAM_TRIPLET_TX_PARITY_EN
        chk("rst_parity",  {31'd0, bus.m_parity},  32'd0);
`endif
        rst = 1'b0;

        // Continuous stream 1..6
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b0);
        chk("c_no_early_valid", {31'd0, bus.m_valid}, 32'd0);
        push(16'h0003, 1'b0);
        chk_beat("c_beat1", 16'h1, 16'h2, 16'h3, 1'b0, 1'b0);
        chk("c_count0", {16'd0, bus.tx_count}, 32'd0);
        push(16'h0004, 1'b0);
        chk("c_drop_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("c_count1", {16'd0, bus.tx_count}, 32'd1);
        push(16'h0005, 1'b0);
        push(16'h0006, 1'b1);
        chk_beat("c_beat2", 16'h4, 16'h5, 16'h6, 1'b0, 1'b1);
        step();
        chk("c_count2", {16'd0, bus.tx_count}, 32'd2);
        chk("c_idle",   {31'd0, bus.m_valid},  32'd0);

        // Early last in COL_B
        push(16'h00AA, 1'b0);
        push(16'h00BB, 1'b1);
        chk("b_flush_valid",  {31'd0, bus.m_valid}, 32'd0);
        chk("b_flush_sready", {31'd0, bus.s_ready}, 32'd0);
        step();
        chk_beat("b_partial", 16'hAA, 16'hBB, 16'h0, 1'b1, 1'b1);
        step();
        chk("b_count3", {16'd0, bus.tx_count}, 32'd3);

        // Backpressure
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b0);
        push(16'h0003, 1'b0);
        bus.m_ready = 1'b0;
        push(16'h0004, 1'b0);
        push(16'h0005, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h0006;
        bus.s_last  = 1'b1;
        #1;
        chk("bp_sready_low", {31'd0, bus.s_ready}, 32'd0);
        chk_beat("bp_hold1", 16'h1, 16'h2, 16'h3, 1'b0, 1'b0);
        step();
        chk("bp_sready_low2", {31'd0, bus.s_ready}, 32'd0);
        chk_beat("bp_hold2", 16'h1, 16'h2, 16'h3, 1'b0, 1'b0);
        chk("bp_count", {16'd0, bus.tx_count}, 32'd3);
        bus.m_ready = 1'b1;
        #1;
        chk("bp_sready_high", {31'd0, bus.s_ready}, 32'd1);
        step();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        chk_beat("bp_next", 16'h4, 16'h5, 16'h6, 1'b0, 1'b1);
        chk("bp_count4", {16'd0, bus.tx_count}, 32'd4);
        step();
        chk("bp_drain_valid", {31'd0, bus.m_valid},  32'd0);
        chk("bp_count5",      {16'd0, bus.tx_count}, 32'd5);

        // Reset mid-frame
        push(16'h0011, 1'b0);
        push(16'h0022, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_valid",  {31'd0, bus.m_valid},  32'd0);
        chk("mr_count",  {16'd0, bus.tx_count}, 32'd0);
        chk("mr_sready", {31'd0, bus.s_ready},  32'd1);
        step();
        chk("mr_valid2", {31'd0, bus.m_valid},  32'd0);
        push(16'h0033, 1'b0);
        push(16'h0044, 1'b0);
        push(16'h0055, 1'b0);
        chk_beat("mr_beat", 16'h33, 16'h44, 16'h55, 1'b0, 1'b0);
        step();
        chk("mr_count1", {16'd0, bus.tx_count}, 32'd1);

`ifdef STREAM_TRIPLET_TX_PARITY_EN
        push(16'h0001, 1'b0);
        push(16'h0002, 1'b0);
        push(16'h0004, 1'b0);
        chk("par_full", {31'd0, bus.m_parity}, 32'd1);
        step();
        push(16'h0003, 1'b1);
        step();
        chk_beat("par_partial_beat", 16'h3, 16'h0, 16'h0, 1'b1, 1'b1);
        chk("par_partial", {31'd0, bus.m_parity}, 32'd0);
        step();
`endif

        // Counter wrap, with an early last in COL_A
        force dut.u_out.tx_count_q = 16'hFFFF;
        #1;
        release dut.u_out.tx_count_q;
        chk("w_preset", {16'd0, bus.tx_count}, 32'hFFFF);
        push(16'h0077, 1'b1);
        chk("w_flush_valid", {31'd0, bus.m_valid}, 32'd0);
        step();
        chk_beat("w_partial_a", 16'h77, 16'h0, 16'h0, 1'b1, 1'b1);
        chk("w_pre_count", {16'd0, bus.tx_count}, 32'hFFFF);
        step();
        chk("w_wrap", {16'd0, bus.tx_count}, 32'h0);
        chk("w_idle", {31'd0, bus.m_valid},  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
